// File: rtl/weapon_hit_detector_pkg.sv
// Shared codes for the weapon hit detector: weapon image codes, game stages,
// knockback directions and hit FSM states.
package weapon_hit_detector_pkg;

   typedef enum logic [3:0] {
      WOODEN_FRONT = 4'h0, WOODEN_BACK = 4'h1, WOODEN_LEFT = 4'h2, WOODEN_RIGHT = 4'h3,
      BASYS_FRONT  = 4'h4, BASYS_BACK  = 4'h5, BASYS_LEFT  = 4'h6, BASYS_RIGHT  = 4'h7,
      CAR_FRONT    = 4'h8, CAR_BACK    = 4'h9, CAR_LEFT    = 4'hA, CAR_RIGHT    = 4'hB,
      WPN_EMPTY    = 4'hF
   } wpn_e;

   localparam logic [3:0] STAGE_INIT     = 4'h0;
   localparam logic [3:0] STAGE_GAMEOVER = 4'hE;
   localparam logic [3:0] STAGE_WIN      = 4'hF;

   typedef enum logic [1:0] {
      DIR_FRONT = 2'd0, DIR_BACK = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0, S_COOL = 2'd1, S_DEAD = 2'd2
   } state_e;

   // Codes C-E are unused images and behave like EMPTY.
   function automatic logic wpn_valid(input logic [3:0] code);
      return code <= CAR_RIGHT;
   endfunction

   function automatic logic stage_active(input logic [3:0] stage);
      return (stage != STAGE_INIT) && (stage != STAGE_GAMEOVER) && (stage != STAGE_WIN);
   endfunction

endpackage

// File: rtl/weapon_hit_detector_aabb.sv
// Axis-aligned box overlap between box A (edge W_A) and box B (edge W_B),
// compared in 11 bits so that box far edges never wrap.
module aabb_overlap #(
   parameter int W_A = 16,
   parameter int W_B = 32
) (
   input  logic [9:0] a_h,
   input  logic [9:0] a_v,
   input  logic [9:0] b_h,
   input  logic [9:0] b_v,
   output logic       ov
);
   localparam logic [10:0] SA = 11'(W_A);
   localparam logic [10:0] SB = 11'(W_B);

   logic ov_h, ov_v;

   // Strict compares: boxes that only share an edge do not overlap.
   assign ov_h = ({1'b0, a_h} < ({1'b0, b_h} + SB)) && ({1'b0, b_h} < ({1'b0, a_h} + SA));
   assign ov_v = ({1'b0, a_v} < ({1'b0, b_v} + SB)) && ({1'b0, b_v} < ({1'b0, a_v} + SA));
   assign ov   = ov_h && ov_v;

endmodule

// File: rtl/weapon_hit_detector.sv
// Per-enemy weapon hit detector: one hit per swing, damage by weapon class,
// invulnerability cooldown, death and knockback reporting.
module weapon_hit_detector
   import weapon_hit_detector_pkg::*;
#(
   parameter int HP_INIT    = 8,
   parameter int DMG_WOODEN = 1,
   parameter int DMG_BASYS  = 2,
   parameter int DMG_CAR    = 4,
   parameter int INVULN_CYC = 50_000_000,
   parameter int WPN_SIZE   = 16,
   parameter int EN_SIZE    = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] stage,
   input  logic [3:0] wpn_state,
   input  logic [9:0] wpn_pos_h,
   input  logic [9:0] wpn_pos_v,
   input  logic [9:0] en_pos_h,
   input  logic [9:0] en_pos_v,
   input  logic       en_spawn,
   output logic       hit,
   output logic       knock_valid,
   output logic [1:0] knock_dir,
   output logic [3:0] hp,
   output logic       dead,
   output logic       invuln
);
   localparam int          CW       = $clog2(INVULN_CYC + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(INVULN_CYC - 1);
   localparam logic [3:0]  HP_RST   = 4'(HP_INIT);

   state_e        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [3:0]    hp_nx, dmg;
   logic [1:0]    dir_nx;
   logic          hit_nx, ov, wv, active;

   aabb_overlap #(.W_A(WPN_SIZE), .W_B(EN_SIZE)) u_ov (
      .a_h (wpn_pos_h),
      .a_v (wpn_pos_v),
      .b_h (en_pos_h),
      .b_v (en_pos_v),
      .ov  (ov)
   );

   assign wv     = wpn_valid(wpn_state);
   assign active = stage_active(stage);

   always_comb begin
      case (wpn_state[3:2])
         2'd0:    dmg = 4'(DMG_WOODEN);
         2'd1:    dmg = 4'(DMG_BASYS);
         default: dmg = 4'(DMG_CAR);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hp        <= HP_RST;
         hit       <= 1'b0;
         knock_dir <= 2'd0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         hp        <= hp_nx;
         hit       <= hit_nx;
         knock_dir <= dir_nx;
      end
   end

   // Spawn and stage 0 outrank everything; game over / win freeze all state.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hp_nx    = hp;
      dir_nx   = knock_dir;
      hit_nx   = 1'b0;
      if (en_spawn || stage == STAGE_INIT) begin
         state_nx = S_IDLE;
         cnt_nx   = '0;
         hp_nx    = HP_RST;
      end else if (active) begin
         if (cnt != '0) cnt_nx = cnt - 1'b1;
         case (state)
            S_IDLE: begin
               if (wv && ov) begin
                  hit_nx   = 1'b1;
                  dir_nx   = wpn_state[1:0];
                  hp_nx    = (hp > dmg) ? hp - dmg : 4'd0;
                  cnt_nx   = CNT_LOAD;
                  state_nx = (hp > dmg) ? S_COOL : S_DEAD;
               end
            end
            // Re-arm needs the swing to end too, so a long swing hits once.
            S_COOL: if (cnt == '0 && !wv) state_nx = S_IDLE;
            default: ;
         endcase
      end
   end

   assign knock_valid = hit;
   assign dead        = (hp == 4'd0);
   assign invuln      = (cnt != '0) && (state != S_DEAD);

endmodule
